// File: rtl/game_pkg.sv
// Shared overworld types and map geometry used by movement and the renderers.
// Direction encoding matches the keyboard decoder output.
package game_pkg;
   localparam int MAP_W = 320;
   localparam int MAP_H = 240;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_PROBE,
      ST_DRAIN,
      ST_DECIDE
   } move_state_t;
endpackage

// File: rtl/map_addr_gen.sv
// Combinational (x,y) to linear map address, row stride MAP_W.
// Zero latency; no flow control.
module map_addr_gen
   import game_pkg::*;
(
   input  logic [8:0]  x,
   input  logic [7:0]  y,
   output logic [18:0] addr
);
   generate
      if (MAP_W == 320) begin : g_shift
         // y*320 = y*256 + y*64
         assign addr = ({11'd0, y} << 8) + ({11'd0, y} << 6) + {10'd0, x};
      end else begin : g_mul
         assign addr = 19'(int'(y) * MAP_W + int'(x));
      end
   endgenerate
endmodule

// File: rtl/player_move_ctrl.sv
// Player movement sequencer: per frame tick, probes the four hitbox corners of the
// clamped target in collision RAM and commits the step only if all read back zero.
module player_move_ctrl
   import game_pkg::*;
#(
   parameter int HIT_W   = 16,
   parameter int HIT_H   = 16,
   parameter int STEP    = 2,
   parameter int START_X = 152,
   parameter int START_Y = 112
)(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        enable,
   input  logic        frame_tick,
   input  logic        key_valid,
   input  logic [1:0]  key_dir,
   output logic [18:0] coll_addr,
   input  logic [3:0]  coll_data,
   output logic [8:0]  pos_x,
   output logic [7:0]  pos_y,
   output logic [1:0]  facing,
   output logic [1:0]  walk_frame,
   output logic        moving,
   output logic        busy
);
   localparam logic signed [10:0] X_MAX  = 11'(MAP_W - HIT_W);
   localparam logic signed [10:0] Y_MAX  = 11'(MAP_H - HIT_H);
   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic [8:0]         X_OFF  = 9'(HIT_W - 1);
   localparam logic [7:0]         Y_OFF  = 8'(HIT_H - 1);

   move_state_t state_q, state_d;
   dir_t        facing_q, facing_d;
   logic [8:0]  pos_x_q, pos_x_d, tx_q, tx_d;
   logic [7:0]  pos_y_q, pos_y_d, ty_q, ty_d;
   logic [1:0]  walk_q, walk_d, corner_q, corner_d;
   logic        blocked_q, blocked_d;
   logic [18:0] coll_addr_q, coll_addr_d;

   logic signed [10:0] sx, sy;
   logic [8:0]  calc_x, ag_x;
   logic [7:0]  calc_y, ag_y;
   logic [1:0]  next_corner;
   logic [18:0] ag_addr;

   always_comb begin
      sx = signed'({2'b00, pos_x_q});
      sy = signed'({3'b000, pos_y_q});
      case (facing_q)
         DIR_UP:   sy = sy - STEP_S;
         DIR_DOWN: sy = sy + STEP_S;
         DIR_LEFT: sx = sx - STEP_S;
         default:  sx = sx + STEP_S;
      endcase
      if (sx < 11'sd0)
         sx = 11'sd0;
      else if (sx > X_MAX)
         sx = X_MAX;
      if (sy < 11'sd0)
         sy = 11'sd0;
      else if (sy > Y_MAX)
         sy = Y_MAX;
      calc_x = sx[8:0];
      calc_y = sy[7:0];
   end

   // One address generator: corner 0 straight from the clamp in CALC, then the
   // following corner from the latched target during each PROBE cycle.
   always_comb begin
      next_corner = corner_q + 2'd1;
      if (state_q == ST_CALC) begin
         ag_x = calc_x;
         ag_y = calc_y;
      end else begin
         ag_x = tx_q + (next_corner[0] ? X_OFF : 9'd0);
         ag_y = ty_q + (next_corner[1] ? Y_OFF : 8'd0);
      end
   end

   map_addr_gen u_addr (
      .x    (ag_x),
      .y    (ag_y),
      .addr (ag_addr)
   );

   always_comb begin
      state_d     = state_q;
      facing_d    = facing_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      tx_d        = tx_q;
      ty_d        = ty_q;
      walk_d      = walk_q;
      corner_d    = corner_q;
      blocked_d   = blocked_q;
      coll_addr_d = coll_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_tick && enable) begin
               if (key_valid) begin
                  facing_d = dir_t'(key_dir);
                  state_d  = ST_CALC;
               end else begin
                  walk_d = 2'd0;
               end
            end
         end
         ST_CALC: begin
            if (calc_x == pos_x_q && calc_y == pos_y_q) begin
               blocked_d = 1'b1;
               state_d   = ST_DECIDE;
            end else begin
               blocked_d   = 1'b0;
               tx_d        = calc_x;
               ty_d        = calc_y;
               corner_d    = 2'd0;
               coll_addr_d = ag_addr;
               state_d     = ST_PROBE;
            end
         end
         ST_PROBE: begin
            // Read data lags the address by one cycle: corner k-1 arrives in PROBE k.
            if (corner_q != 2'd0 && coll_data != 4'd0)
               blocked_d = 1'b1;
            if (corner_q == 2'd3) begin
               state_d = ST_DRAIN;
            end else begin
               corner_d    = next_corner;
               coll_addr_d = ag_addr;
            end
         end
         ST_DRAIN: begin
            if (coll_data != 4'd0)
               blocked_d = 1'b1;
            state_d = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (!blocked_q) begin
               pos_x_d = tx_q;
               pos_y_d = ty_q;
               walk_d  = walk_q + 2'd1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         facing_q    <= DIR_DOWN;
         pos_x_q     <= 9'(START_X);
         pos_y_q     <= 8'(START_Y);
         tx_q        <= '0;
         ty_q        <= '0;
         walk_q      <= '0;
         corner_q    <= '0;
         blocked_q   <= 1'b0;
         coll_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         facing_q    <= facing_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         tx_q        <= tx_d;
         ty_q        <= ty_d;
         walk_q      <= walk_d;
         corner_q    <= corner_d;
         blocked_q   <= blocked_d;
         coll_addr_q <= coll_addr_d;
      end
   end

   assign coll_addr  = coll_addr_q;
   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign facing     = facing_q;
   assign walk_frame = walk_q;
   assign moving     = (state_q == ST_DECIDE) && !blocked_q;
   assign busy       = (state_q != ST_IDLE);
endmodule
